ahb_cpu_bridge: RTL

- Upstream bus master for the AHB-Lite memory/peripheral fabric (ROM, RAM, GPIO, timer).
- Converts single CPU load/store requests (valid/ready) into AHB-Lite address and data phases, and returns read data as a one-cycle response pulse.
- The fabric is word-only, so byte/halfword stores run as read-modify-write; loads extract and extend the addressed lane.
- One transaction outstanding at a time; the fabric has no wait states (no HREADY).

---
 rtl/ahb_cpu_bridge.sv | 119 +++++++++++
 1 files changed

// File: rtl/ahb_cpu_bridge.sv
// CPU load/store to AHB-Lite master bridge. One request in flight at a time. The fabric is
// word-only with no wait states, so sub-word stores run as read-modify-write.
module ahb_cpu_bridge #(
  parameter logic [31:0] RESET_HADDR = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_A, WR_D, RESP, ERR} state_t;

  typedef struct packed {
    logic [1:0]  lane;
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
  } req_t;

  state_t      state, state_nxt;
  req_t        req_q;
  logic [31:0] old_q;
  logic        accept, bad;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && (state == IDLE);
  assign bad       = (req_size == 2'b11) ||
                     (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  function automatic logic [31:0] extract(input logic [31:0] w, input req_t r);
    logic [31:0] sh;
    sh = w >> {r.lane, 3'b000};
    case (r.size)
      2'b00:   extract = r.sgn ? {{24{sh[7]}}, sh[7:0]} : {24'b0, sh[7:0]};
      2'b01:   extract = r.sgn ? {{16{sh[15]}}, sh[15:0]} : {16'b0, sh[15:0]};
      default: extract = w;
    endcase
  endfunction

  // Addressed lane comes from wdata, other lanes from the word read in RD_D.
  function automatic logic [31:0] merge(input logic [31:0] old, input req_t r);
    logic [31:0] mask;
    case (r.size)
      2'b00:   mask = 32'h0000_00FF << {r.lane, 3'b000};
      2'b01:   mask = 32'h0000_FFFF << {r.lane[1], 4'b0000};
      default: mask = 32'hFFFF_FFFF;
    endcase
    merge = (old & ~mask) | ((r.wdata << {r.lane, 3'b000}) & mask);
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        if (bad)                               state_nxt = ERR;
        else if (req_write && req_size == 2'b10) state_nxt = WR_A;
        else                                   state_nxt = RD_A;
      end
      RD_A:    state_nxt = RD_D;
      RD_D:    state_nxt = req_q.write ? WR_A : RESP;
      WR_A:    state_nxt = WR_D;
      WR_D:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= IDLE;
      req_q     <= '0;
      old_q     <= '0;
      HADDR     <= RESET_HADDR;
      HWRITE    <= 1'b0;
      HWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      HWRITE    <= (state_nxt == WR_A);
      rsp_valid <= 1'b0;
      if (accept)
        req_q <= '{lane: req_addr[1:0], write: req_write, size: req_size,
                   sgn: req_signed, wdata: req_wdata};
      // RMW reuses this address for its write phase, so it is only loaded at accept.
      if (accept && !bad) HADDR <= {req_addr[31:2], 2'b00};
      if (state == RD_D)  old_q <= HRDATA;
      if (state == WR_A)  HWDATA <= merge(old_q, req_q);
      if (state == RESP) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b0;
        rsp_rdata <= req_q.write ? 32'h0 : extract(old_q, req_q);
      end
      if (state == ERR) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

endmodule
